alu_op_sequencer: RTL

Sequences single operations into the ALU and its 12-input flag-value mux, one at a time. Accepts an opcode from the control unit via valid/ready. Drives a stable `alu_opcode` to the ALU and flag mux for the full execution window, then latches the selected 4-bit flag value into a flag register and pulses `done`. Rejects opcodes the flag mux does not decode (4'b1011–4'b1110). Supports configurable multi-cycle opcodes.

---
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Issues one ALU opcode at a time, holds it stable for the opcode's latency,
// then captures the flag-mux result into flags_q with a done pulse.
module alu_op_sequencer #(
    parameter logic [15:0] MULTI_MASK = 16'h0300,
    parameter int          MULTI_LAT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_opcode,
    output logic       req_ready,
    input  logic       abort,
    output logic [3:0] alu_opcode,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags_q,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_opcode_q, alu_opcode_d;
    logic [3:0] flags_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic       req_legal;
    logic [3:0] req_cnt_init;

    // The flag mux decodes 0..10 and 15; 11..14 have no flag source.
    assign req_legal    = (req_opcode <= 4'd10) || (req_opcode == 4'd15);
    assign req_cnt_init = MULTI_MASK[req_opcode] ? MULTI_CNT : 4'd0;

    always_comb begin
        // NOTE: every signal gets a hold/idle default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        flags_d      = flags_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        alu_opcode_d = req_opcode;
                        cnt_d        = req_cnt_init;
                        state_d      = EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // Abort wins over a completion landing on the same edge.
                if (abort) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    flags_d = alu_flags;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_opcode_q <= 4'd0;
            flags_q      <= 4'd0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            flags_q      <= flags_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign busy       = (state_q == EXEC);
    assign alu_opcode = alu_opcode_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule
